// File: rtl/mem_req_bridge.sv
// rtl/mem_req_bridge.sv - request/grant front end that queues core accesses and issues them to storage_controller
// Classifies each access as SRAM or external QSPI at grant time and rejects what the controller cannot serve.
module mem_req_bridge #(
    parameter int          MEM_W      = 32,
    parameter int          MEM_SZ     = 262144,
    parameter logic [31:0] SRAM_LIMIT = 32'h0000_0FFF,
    parameter int          DEPTH      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_mode,
    input  logic               mem_req,
    output logic               mem_gnt,
    input  logic               mem_we,
    input  logic [MEM_W/8-1:0] mem_be,
    input  logic [31:0]        mem_addr,
    input  logic [MEM_W-1:0]   mem_wdata,
    output logic               mem_rvalid,
    output logic [MEM_W-1:0]   mem_rdata,
    output logic               mem_err,
    output logic               memory_access,
    output logic               memory_is_writing,
    output logic [31:0]        addr,
    output logic [31:0]        d_in,
    output logic [MEM_W/8-1:0] mem_be_o,
    output logic               external_storage_access,
    output logic               set_programming_mode,
    input  logic [31:0]        d_out,
    input  logic               out_valid
);

    localparam int          PTR_W    = $clog2(DEPTH);
    localparam logic [31:0] MEM_SZ_W = 32'(MEM_SZ);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0]         state;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;

    logic               fifo_we   [DEPTH];
    logic [MEM_W/8-1:0] fifo_be   [DEPTH];
    logic [31:0]        fifo_addr [DEPTH];
    logic [MEM_W-1:0]   fifo_wdata[DEPTH];
    logic               fifo_ext  [DEPTH];
    logic               fifo_err  [DEPTH];

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic new_ext;
    logic new_err;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign mem_gnt = mem_req & ~full & ~prog_mode;
    assign push    = mem_req & mem_gnt;
    assign pop     = (state == S_IDLE) & ~empty;

    // External storage is read-only and bounded by MEM_SZ; misalignment is always rejected.
    assign new_ext = (mem_addr >= SRAM_LIMIT);
    assign new_err = (mem_addr[1:0] != 2'b00)
                   | (new_ext & mem_we)
                   | (new_ext & (mem_addr >= MEM_SZ_W));

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_we[wr_ptr]    <= mem_we;
            fifo_be[wr_ptr]    <= mem_be;
            fifo_addr[wr_ptr]  <= mem_addr;
            fifo_wdata[wr_ptr] <= mem_wdata;
            fifo_ext[wr_ptr]   <= new_ext;
            fifo_err[wr_ptr]   <= new_err;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                   <= S_IDLE;
            mem_rvalid              <= 1'b0;
            mem_rdata               <= '0;
            mem_err                 <= 1'b0;
            memory_access           <= 1'b0;
            memory_is_writing       <= 1'b0;
            addr                    <= '0;
            d_in                    <= '0;
            mem_be_o                <= '0;
            external_storage_access <= 1'b0;
            set_programming_mode    <= 1'b0;
        end else begin
            set_programming_mode <= prog_mode;
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        if (fifo_err[rd_ptr] || prog_mode) begin
                            mem_rvalid <= 1'b1;
                            mem_err    <= 1'b1;
                            mem_rdata  <= '0;
                            state      <= S_RESP;
                        end else begin
                            addr                    <= fifo_addr[rd_ptr];
                            d_in                    <= fifo_wdata[rd_ptr];
                            mem_be_o                <= fifo_be[rd_ptr];
                            memory_is_writing       <= fifo_we[rd_ptr];
                            external_storage_access <= fifo_ext[rd_ptr];
                            memory_access           <= 1'b1;
                            state                   <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    // Programming mode aborts the in-flight access ahead of any completion.
                    if (prog_mode) begin
                        memory_access <= 1'b0;
                        mem_rvalid    <= 1'b1;
                        mem_err       <= 1'b1;
                        mem_rdata     <= '0;
                        state         <= S_RESP;
                    end else if (out_valid) begin
                        memory_access <= 1'b0;
                        mem_rvalid    <= 1'b1;
                        mem_err       <= 1'b0;
                        mem_rdata     <= memory_is_writing ? '0 : d_out;
                        state         <= S_RESP;
                    end
                end
                S_RESP: begin
                    mem_rvalid <= 1'b0;
                    mem_err    <= 1'b0;
                    mem_rdata  <= '0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_bridge.sv
// tb/tb_mem_req_bridge.sv - scoreboard bench for mem_req_bridge with a behavioural controller model
module tb_mem_req_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        prog_mode = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_gnt;
    logic        mem_we = 1'b0;
    logic [3:0]  mem_be = 4'h0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        memory_access;
    logic        memory_is_writing;
    logic [31:0] addr;
    logic [31:0] d_in;
    logic [3:0]  mem_be_o;
    logic        external_storage_access;
    logic        set_programming_mode;
    logic [31:0] d_out = 32'h0;
    logic        out_valid = 1'b0;

    mem_req_bridge #(
        .MEM_W(32), .MEM_SZ(262144), .SRAM_LIMIT(32'h0000_0FFF), .DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .prog_mode(prog_mode),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .memory_access(memory_access), .memory_is_writing(memory_is_writing),
        .addr(addr), .d_in(d_in), .mem_be_o(mem_be_o),
        .external_storage_access(external_storage_access),
        .set_programming_mode(set_programming_mode),
        .d_out(d_out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   ext_delay = 10;
    int   ma_cycles = 0;
    int   stab_viol = 0;

    logic        cap_we, cap_ext, prev_ma;
    logic [3:0]  cap_be;
    logic [31:0] cap_addr, cap_din;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Controller model: answers k cycles after it first sees memory_access, then waits for it to drop.
    int   ctl_cnt = 0;
    logic ctl_armed = 1'b1;
    always @(negedge clk) begin
        if (!rst) begin
            ctl_cnt   = 0;
            ctl_armed = 1'b1;
            out_valid = 1'b0;
        end else begin
            if (out_valid) begin
                out_valid = 1'b0;
            end else if (ctl_cnt > 0) begin
                if (!memory_access) ctl_cnt = 0;
                else begin
                    ctl_cnt--;
                    if (ctl_cnt == 0) begin
                        out_valid = 1'b1;
                        d_out     = (addr == 32'h10) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | addr);
                        ctl_armed = 1'b0;
                    end
                end
            end else if (memory_access && ctl_armed) begin
                ctl_cnt = external_storage_access ? ext_delay : 1;
            end
            if (!memory_access) ctl_armed = 1'b1;
        end
    end

    // Response monitor and controller-side observers.
    always @(negedge clk) begin
        if (memory_access) begin
            ma_cycles++;
            if (!prev_ma) begin
                cap_we   = memory_is_writing;
                cap_be   = mem_be_o;
                cap_addr = addr;
                cap_din  = d_in;
                cap_ext  = external_storage_access;
            end else if (cap_we !== memory_is_writing || cap_be !== mem_be_o || cap_addr !== addr ||
                         cap_din !== d_in || cap_ext !== external_storage_access) begin
                stab_viol++;
            end
        end
        prev_ma = memory_access;
        if (mem_rvalid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", 64'(mem_rvalid), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_rdata", 64'(mem_rdata), 64'(e.rdata));
                check("resp_err", 64'(mem_err), 64'(e.err));
                if (e.cyc >= 0) check("resp_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee,
                         input int lat, output int waited);
        exp_t e;
        mem_req = 1'b1; mem_we = we; mem_be = be; mem_addr = a; mem_wdata = wd;
        #1;
        waited = 0;
        while (!mem_gnt && waited < 50) begin
            @(negedge clk); #1;
            waited++;
        end
        if (!mem_gnt) begin
            check("grant_timeout", 64'(mem_gnt), 64'd1);
        end else begin
            e.rdata = er; e.err = ee; e.cyc = (lat < 0) ? -1 : cyc + lat;
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        mem_req = 1'b0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w;
        int waits[6];
        prev_ma = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              64'({mem_gnt, mem_rvalid, mem_rdata, mem_err, memory_access, memory_is_writing,
                   mem_be_o, external_storage_access, set_programming_mode}), 64'd0);
        check("reset_addr_din", {addr, d_in}, 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        ma_cycles = 0;
        issue(1'b0, 4'hF, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 4, w);
        drain();
        check("sram_read_ma_cycles", 64'(ma_cycles), 64'd2);

        issue(1'b1, 4'b0011, 32'h20, 32'h1234_5678, 32'h0, 1'b0, 4, w);
        drain();
        check("write_is_writing", 64'(cap_we), 64'd1);
        check("write_be", 64'(cap_be), 64'h3);
        check("write_din", 64'(cap_din), 64'h1234_5678);
        check("write_addr", 64'(cap_addr), 64'h20);
        check("write_ext", 64'(cap_ext), 64'd0);

        ma_cycles = 0; stab_viol = 0; ext_delay = 10;
        issue(1'b0, 4'hF, 32'h2000, 32'h0, 32'hC0DE_2000, 1'b0, 13, w);
        drain();
        check("ext_flag", 64'(cap_ext), 64'd1);
        check("ext_stable", 64'(stab_viol), 64'd0);
        check("ext_ma_cycles", 64'(ma_cycles), 64'd11);

        ma_cycles = 0;
        issue(1'b1, 4'hF, 32'h3000, 32'hAAAA_5555, 32'h0, 1'b1, 2, w);
        drain();
        issue(1'b0, 4'hF, 32'h11, 32'h0, 32'h0, 1'b1, 2, w);
        drain();
        issue(1'b0, 4'hF, 32'h0004_0000, 32'h0, 32'h0, 1'b1, 2, w);
        drain();
        check("err_no_access", 64'(ma_cycles), 64'd0);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            a = 32'h40 + 32'(4 * i);
            issue(1'b0, 4'hF, a, 32'h0, 32'hC0DE_0000 | a, 1'b0, -1, waits[i]);
        end
        drain();
        check("b2b_first5_no_wait", 64'(waits[0] + waits[1] + waits[2] + waits[3] + waits[4]), 64'd0);
        check("b2b_full_refusal", 64'(waits[5]), 64'd1);

        ext_delay = 20;
        issue(1'b0, 4'hF, 32'h2000, 32'h0, 32'hC0DE_2000, 1'b0, -1, w);
        issue(1'b0, 4'hF, 32'h50, 32'h0, 32'hC0DE_0050, 1'b0, -1, w);
        issue(1'b0, 4'hF, 32'h54, 32'h0, 32'hC0DE_0054, 1'b0, -1, w);
        mem_req = 1'b0;
        repeat (3) @(negedge clk);
        check("prog_in_issue", 64'(memory_access), 64'd1);
        foreach (exp_q[i]) begin
            exp_q[i].rdata = 32'h0;
            exp_q[i].err   = 1'b1;
        end
        prog_mode = 1'b1; mem_req = 1'b1; mem_addr = 32'h58;
        #1;
        check("prog_gnt_low", 64'(mem_gnt), 64'd0);
        @(negedge clk);
        check("prog_ma_cleared", 64'(memory_access), 64'd0);
        check("prog_set_mode", 64'(set_programming_mode), 64'd1);
        drain();
        prog_mode = 1'b0;
        ext_delay = 10;
        repeat (2) @(negedge clk);

        issue(1'b0, 4'hF, 32'h60, 32'h0, 32'hC0DE_0060, 1'b0, -1, w);
        mem_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset_ma", 64'(memory_access), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        check("post_reset_idle", 64'({memory_access, mem_rvalid}), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
